// File: rtl/axis_vec_gen_if.sv
// AXI4-Stream beat bundle used by the test-vector generator.
// The generator drives the master side; the sink uses the slave side.
interface axis_vec_gen_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_vec_gen.sv
// AXI4-Stream test-vector packet source: ramp, LFSR or impulse packets
// with programmable length, count and fixed inter-packet gap.
module axis_vec_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [1:0]            MODE,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic [LEN_WIDTH-1:0]  PKT_LEN,
    input  logic [LEN_WIDTH-1:0]  NUM_PKTS,
    axis_vec_gen_if.master        m_axis,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [31:0]           BEAT_CNT
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Maximal-length Galois feedback masks; 16 bits uses 0xB400.
    function automatic logic [DATA_WIDTH-1:0] lfsr_taps(input int w);
        logic [31:0] m;
        case (w)
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_B400;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            default: m = 32'h8020_0003;
        endcase
        return DATA_WIDTH'(m);
    endfunction

    localparam logic [DATA_WIDTH-1:0] TAPS = lfsr_taps(DATA_WIDTH);

    // Value of the next beat given the current one and its packet index.
    function automatic logic [DATA_WIDTH-1:0] gen_next(
        input logic [1:0]            md,
        input logic [DATA_WIDTH-1:0] cur,
        input logic [LEN_WIDTH-1:0]  idx,
        input logic [DATA_WIDTH-1:0] sd
    );
        logic [DATA_WIDTH-1:0] v;
        case (md)
            2'd1:    v = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
            2'd2:    v = (idx == '0) ? sd : '0;
            default: v = cur + DATA_WIDTH'(1);
        endcase
        return v;
    endfunction

    state_t                state_q, state_n;
    logic                  tvalid_q, tvalid_n;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_n;
    logic                  tlast_q, tlast_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic [31:0]           cnt_q, cnt_n;
    logic [1:0]            mode_q, mode_n;
    logic [DATA_WIDTH-1:0] seed_q, seed_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n;
    logic [LEN_WIDTH-1:0]  left_q, left_n;
    logic [LEN_WIDTH-1:0]  idx_q, idx_n;
    logic [GW-1:0]         gap_q, gap_n;
    logic                  abort_q, abort_n;
    logic                  accept;
    logic                  go_fin;

    assign accept        = tvalid_q & m_axis.tready;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign BEAT_CNT      = cnt_q;

    // Next-state and next-output logic for the packet sequencer.
    always_comb begin
        state_n  = state_q;
        tvalid_n = tvalid_q;
        tdata_n  = tdata_q;
        tlast_n  = tlast_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        cnt_n    = cnt_q;
        mode_n   = mode_q;
        seed_n   = seed_q;
        len_n    = len_q;
        left_n   = left_q;
        idx_n    = idx_q;
        gap_n    = gap_q;
        abort_n  = abort_q;
        go_fin   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    mode_n  = MODE;
                    seed_n  = SEED;
                    len_n   = (PKT_LEN == '0) ? LEN_WIDTH'(1) : PKT_LEN;
                    left_n  = NUM_PKTS;
                    idx_n   = '0;
                    cnt_n   = '0;
                    abort_n = 1'b0;
                    if (NUM_PKTS == '0) begin
                        go_fin = 1'b1;
                    end else begin
                        state_n  = SEND;
                        busy_n   = 1'b1;
                        tvalid_n = 1'b1;
                        tdata_n  = (MODE == 2'd1 && SEED == '0) ?
                                   DATA_WIDTH'(1) : SEED;
                        tlast_n  = (PKT_LEN <= LEN_WIDTH'(1));
                    end
                end
            end
            SEND: begin
                abort_n = abort_q | ABORT;
                if (accept) begin
                    if (cnt_q != '1) cnt_n = cnt_q + 32'd1;
                    if (abort_n) begin
                        go_fin = 1'b1;
                    end else if (tlast_q) begin
                        left_n = left_q - LEN_WIDTH'(1);
                        if (left_q == LEN_WIDTH'(1)) begin
                            go_fin = 1'b1;
                        end else begin
                            idx_n   = '0;
                            tdata_n = gen_next(mode_q, tdata_q, '0, seed_q);
                            tlast_n = (len_q == LEN_WIDTH'(1));
                            if (GAP_CYCLES != 0) begin
                                state_n  = GAP;
                                tvalid_n = 1'b0;
                                gap_n    = GW'(GAP_CYCLES - 1);
                            end
                        end
                    end else begin
                        idx_n   = idx_q + LEN_WIDTH'(1);
                        tdata_n = gen_next(mode_q, tdata_q, idx_n, seed_q);
                        tlast_n = (idx_n == len_q - LEN_WIDTH'(1));
                    end
                end
            end
            GAP: begin
                if (ABORT) begin
                    go_fin = 1'b1;
                end else if (gap_q == '0) begin
                    state_n  = SEND;
                    tvalid_n = 1'b1;
                end else begin
                    gap_n = gap_q - GW'(1);
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (go_fin) begin
            state_n  = FINISH;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
        end
    end

    // State and registered outputs, cleared immediately on reset.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= '0;
            seed_q   <= '0;
            len_q    <= '0;
            left_q   <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            tvalid_q <= tvalid_n;
            tdata_q  <= tdata_n;
            tlast_q  <= tlast_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            cnt_q    <= cnt_n;
            mode_q   <= mode_n;
            seed_q   <= seed_n;
            len_q    <= len_n;
            left_q   <= left_n;
            idx_q    <= idx_n;
            gap_q    <= gap_n;
            abort_q  <= abort_n;
        end
    end
endmodule

// File: doc/axis_vec_gen.md
Name: axis_vec_gen

Overview:
AXI4-Stream transmitter that generates test-vector packets to drive the FIR datapath's AXI-ST slave input (S_AXIS_T* of the FIR top level). It is the stimulus-source end of that stream interface and provides built-in self-test (BIST) fill capability.
- Packets are ramp, LFSR or impulse sequences.
- Packet length, packet count and inter-packet gap are programmable.
- Sink backpressure is honoured exactly per AXI-ST rules.

Parameters:
DATA_WIDTH, 16, width of M_AXIS_TDATA (8..32)
LEN_WIDTH, 16, width of packet-length and packet-count fields
GAP_CYCLES, 2, idle cycles with M_AXIS_TVALID low between packets (0 allowed)

Ports:
S_AXIS_ACLK  in  1  clock
S_AXIS_ARESETN  in  1  asynchronous active-low reset
START  in  1  single-cycle start pulse; ignored while BUSY=1
ABORT  in  1  stop after the current beat is accepted
MODE  in  2  0=ramp, 1=LFSR, 2=impulse, 3=reserved (behaves as ramp)
SEED  in  DATA_WIDTH  ramp start / LFSR seed / impulse amplitude
PKT_LEN  in  LEN_WIDTH  beats per packet; 0 is treated as 1
NUM_PKTS  in  LEN_WIDTH  packets per run
M_AXIS_TREADY  in  1  sink ready
M_AXIS_TVALID  out  1  data valid
M_AXIS_TDATA  out  DATA_WIDTH  data
M_AXIS_TLAST  out  1  last beat of packet
BUSY  out  1  run in progress
DONE  out  1  one-cycle pulse at end of run
BEAT_CNT  out  32  total accepted beats in current/last run

Behaviour:
- Reset values: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, BUSY=0, DONE=0, BEAT_CNT=0, FSM=IDLE.
- All outputs are registered. A beat is accepted when TVALID&TREADY at a rising edge.
- States: IDLE, SEND, GAP, FINISH.
- IDLE:
  - On START, latch MODE/SEED/PKT_LEN/NUM_PKTS and clear BEAT_CNT.
  - If NUM_PKTS=0, go to FINISH. Otherwise go to SEND.
  - BUSY=1 from the cycle after START.
- SEND:
  - First beat has TVALID=1 in the cycle after START (latency 1).
  - TVALID, once asserted, stays high until accepted. TDATA/TLAST are held stable while TVALID&!TREADY.
  - On each accepted beat: BEAT_CNT++; advance the data generator; present the next beat in the following cycle with no bubble.
  - TLAST=1 on beat index PKT_LEN-1 of each packet.
  - After an accepted TLAST:
    - If it was the last packet, go to FINISH.
    - Else if GAP_CYCLES>0, go to GAP.
    - Else stay in SEND with the first beat of the next packet in the next cycle.
- GAP: TVALID=0 for exactly GAP_CYCLES cycles, then go to SEND.
- FINISH: DONE=1 for one cycle, BUSY=0 in the same cycle, then go to IDLE.
- Data generation (width rules):
  - Ramp: beat value = SEED + n, where n counts accepted beats across the whole run. Arithmetic is modulo 2^DATA_WIDTH (wraps 0xFFFF->0x0000).
  - LFSR:
    - Galois register, right-shifting, of width DATA_WIDTH. For 16 bits the feedback mask is 0xB400.
    - The register is loaded from SEED, with SEED=0 replaced by 1.
    - TDATA = register value. The register advances once per accepted beat and is never reseeded between packets.
  - Impulse: beat 0 of every packet = SEED; all other beats = 0.
- ABORT:
  - If TVALID=1, the current beat completes normally. After it is accepted, go to FINISH, forcing TLAST=0 on nothing further; no extra beat is sent.
  - If TVALID=0 (IDLE/GAP), go to FINISH next cycle; in IDLE, ABORT is ignored.
  - ABORT and START together in IDLE: START wins.
- START while BUSY is ignored; the latched parameters are unaffected.
- Input changes during a run have no effect.
- Asynchronous reset mid-packet: outputs immediately return to reset values and the packet is truncated. The sink side handles the truncation on its own reset.
- BEAT_CNT saturates at 0xFFFFFFFF.

Test Plan:
- Ramp, SEED=0x0010, PKT_LEN=4, NUM_PKTS=2, GAP_CYCLES=2, TREADY=1 -> data 0x10..0x13 with TLAST on 0x13, 2 idle cycles, then 0x14..0x17 with TLAST on 0x17. DONE pulses one cycle after the last beat; BEAT_CNT=8.
- Backpressure: ramp PKT_LEN=3, TREADY toggling 1,0,0,1,0,1 -> each beat held stable while stalled. Accepted sequence is SEED, SEED+1, SEED+2 with no duplicates or drops; TVALID never drops before acceptance.
- LFSR, SEED=0 (forced 1), PKT_LEN=3, NUM_PKTS=1 -> 0x0001, 0xB400, 0x5A00, with TLAST on the third beat.
- Impulse, SEED=0x7FFF, PKT_LEN=4, NUM_PKTS=2, GAP_CYCLES=0 -> 0x7FFF,0,0,0,0x7FFF,0,0,0 back-to-back, TLAST on beats 3 and 7.
- Edge cases:
  - NUM_PKTS=0 -> no TVALID, DONE one cycle later.
  - PKT_LEN=0 -> single-beat packets with TLAST=1.
  - Ramp SEED=0xFFFE, length 3 -> 0xFFFE, 0xFFFF, 0x0000.
- ABORT asserted while beat 2 of a 10-beat packet is stalled -> beat 2 delivered after TREADY, no further beats, DONE pulses, BEAT_CNT=3. Async reset asserted mid-packet -> TVALID=0 immediately, BUSY=0.
